attention_p_stream_reader: RTL and testbench

- Initiator-side reader for the softmax probability read port (p_re/p_tq/p_tk -> p_rdata/p_rvalid).
- After the softmax engine reports done, walks all T x T entries of P in row-major order and streams them downstream on a valid/ready interface tagged with row/col and last flags.
- Credit-limited issue plus a small FIFO absorb the fixed read latency and downstream back-pressure; downstream is the P x V accumulation stage.

---
 rtl/attention_p_stream_reader_pkg.sv | 17 +
 rtl/attention_p_stream_reader_if.sv | 24 ++
 rtl/attention_p_stream_reader_fifo.sv | 47 ++++
 rtl/attention_p_stream_reader.sv | 147 ++++++++++++++
 tb/tb_attention_p_stream_reader.sv | 317 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/attention_p_stream_reader_pkg.sv
// Shared types and helpers for the softmax P read-out stream reader.
package attn_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_SRC,
    ISSUE,
    DRAIN,
    DONE
  } pstr_state_t;

  // Index width for a T-entry dimension; never narrower than one bit.
  function automatic int idx_w(input int t);
    return (t <= 1) ? 1 : $clog2(t);
  endfunction

endpackage

// File: rtl/attention_p_stream_reader_if.sv
// Downstream P element stream. A beat transfers on a cycle where m_valid && m_ready;
// once m_valid rises it holds, with a stable payload, until that transfer happens.
interface attention_p_stream_reader_if #(
  parameter int DATA_W = 32,
  parameter int ROW_W  = 3
);
  logic              m_valid;
  logic              m_ready;
  logic [DATA_W-1:0] m_data;
  logic [ROW_W-1:0]  m_row;
  logic [ROW_W-1:0]  m_col;
  logic              m_last_col;
  logic              m_last;

  modport master (
    output m_valid, m_data, m_row, m_col, m_last_col, m_last,
    input  m_ready
  );

  modport slave (
    input  m_valid, m_data, m_row, m_col, m_last_col, m_last,
    output m_ready
  );
endinterface

// File: rtl/attention_p_stream_reader_fifo.sv
// Synchronous response FIFO; the head entry is visible combinationally on rdata.
module attn_stream_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [DATA_W-1:0]        wdata,
  input  logic                     pop,
  output logic [DATA_W-1:0]        rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]     count_q;
  logic              do_push, do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rdata   = mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Storage is cleared so the stream payload reads as zero straight after reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= wdata;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end
endmodule

// File: rtl/attention_p_stream_reader.sv
// Walks the T x T softmax P matrix row-major through the P read port and streams it
// downstream; issue is credit-limited so reads in flight plus buffered never exceed the FIFO.
module attention_p_stream_reader
  import attn_pkg::*;
#(
  parameter  int T          = 8,
  parameter  int DATA_W     = 32,
  parameter  int FIFO_DEPTH = 4,
  localparam int ROW_W      = idx_w(T)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic                        sm_done,
  output logic                        busy,
  output logic                        done,
  output logic                        p_re,
  output logic [ROW_W-1:0]            p_tq,
  output logic [ROW_W-1:0]            p_tk,
  input  logic [DATA_W-1:0]           p_rdata,
  input  logic                        p_rvalid,
  attention_p_stream_reader_if.master m_if,
  output pstr_state_t                 dbg_state_o
);
  localparam int               CW       = $clog2(FIFO_DEPTH) + 1;
  localparam logic [ROW_W-1:0] LAST_IDX = ROW_W'(T - 1);

  pstr_state_t       state_q, state_d;
  logic [ROW_W-1:0]  iss_row_q, iss_row_d, iss_col_q, iss_col_d;
  logic [ROW_W-1:0]  out_row_q, out_row_d, out_col_q, out_col_d;
  logic [CW-1:0]     outst_q, outst_d, fifo_count;
  logic [CW:0]       credit_used;
  logic [DATA_W-1:0] fifo_head;
  logic              fifo_full, fifo_empty, active, rsp_accept, beat_hs, clear_cnt;

  assign active      = (state_q == ISSUE) || (state_q == DRAIN);
  assign rsp_accept  = p_rvalid && active && !fifo_full;
  assign beat_hs     = m_if.m_valid && m_if.m_ready;
  assign credit_used = {1'b0, outst_q} + {1'b0, fifo_count};

  attn_stream_fifo #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (rsp_accept),
    .wdata (p_rdata),
    .pop   (beat_hs),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    state_d   = state_q;
    p_re      = 1'b0;
    clear_cnt = 1'b0;
    case (state_q)
      IDLE:     if (start) state_d = WAIT_SRC;
      WAIT_SRC: if (sm_done) begin
        state_d   = ISSUE;
        clear_cnt = 1'b1;
      end
      ISSUE: begin
        p_re = (credit_used < (CW + 1)'(FIFO_DEPTH));
        if (p_re && iss_row_q == LAST_IDX && iss_col_q == LAST_IDX) state_d = DRAIN;
      end
      DRAIN:    if (outst_q == '0 && fifo_empty) state_d = DONE;
      DONE:     state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Both walk counters advance col-first with explicit wrap at T-1.
  always_comb begin
    iss_row_d = iss_row_q;
    iss_col_d = iss_col_q;
    out_row_d = out_row_q;
    out_col_d = out_col_q;
    if (clear_cnt) begin
      iss_row_d = '0;
      iss_col_d = '0;
      out_row_d = '0;
      out_col_d = '0;
    end else begin
      if (p_re) begin
        if (iss_col_q == LAST_IDX) begin
          iss_col_d = '0;
          iss_row_d = (iss_row_q == LAST_IDX) ? '0 : iss_row_q + 1'b1;
        end else begin
          iss_col_d = iss_col_q + 1'b1;
        end
      end
      if (beat_hs) begin
        if (out_col_q == LAST_IDX) begin
          out_col_d = '0;
          out_row_d = (out_row_q == LAST_IDX) ? '0 : out_row_q + 1'b1;
        end else begin
          out_col_d = out_col_q + 1'b1;
        end
      end
    end
  end

  // Responses arriving outside a pass are not counted, so late data after an abort is dropped.
  always_comb begin
    outst_d = outst_q;
    if (!active) begin
      outst_d = '0;
    end else begin
      case ({p_re, rsp_accept})
        2'b10:   outst_d = outst_q + 1'b1;
        2'b01:   outst_d = outst_q - 1'b1;
        default: outst_d = outst_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      iss_row_q <= '0;
      iss_col_q <= '0;
      out_row_q <= '0;
      out_col_q <= '0;
      outst_q   <= '0;
    end else begin
      state_q   <= state_d;
      iss_row_q <= iss_row_d;
      iss_col_q <= iss_col_d;
      out_row_q <= out_row_d;
      out_col_q <= out_col_d;
      outst_q   <= outst_d;
    end
  end

  assign busy             = (state_q != IDLE);
  assign done             = (state_q == DONE);
  assign p_tq             = iss_row_q;
  assign p_tk             = iss_col_q;
  assign dbg_state_o      = state_q;
  assign m_if.m_valid     = !fifo_empty;
  assign m_if.m_data      = fifo_head;
  assign m_if.m_row       = out_row_q;
  assign m_if.m_col       = out_col_q;
  assign m_if.m_last_col  = (out_col_q == LAST_IDX);
  assign m_if.m_last      = (out_col_q == LAST_IDX) && (out_row_q == LAST_IDX);
endmodule

// File: tb/tb_attention_p_stream_reader.sv
// Bench for attention_p_stream_reader: T=4 and T=5 instances fed by a 2-cycle-latency P source.
module tb_attention_p_stream_reader;
  import attn_pkg::*;

  localparam int          T4   = 4;
  localparam int          T5   = 5;
  localparam int          DW   = 32;
  localparam int          FD   = 4;
  localparam int          RW4  = idx_w(T4);
  localparam int          RW5  = idx_w(T5);
  localparam logic [31:0] BASE = 32'h3E00_0000;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  // ---------------- DUT T=4 ----------------
  logic           start4, sm_done4, busy4, done4, p_re4, p_rvalid4;
  logic [RW4-1:0] p_tq4, p_tk4;
  logic [DW-1:0]  p_rdata4;
  pstr_state_t    dbg_state4;
  attention_p_stream_reader_if #(.DATA_W(DW), .ROW_W(RW4)) if4 ();

  attention_p_stream_reader #(.T(T4), .DATA_W(DW), .FIFO_DEPTH(FD)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .sm_done(sm_done4),
    .busy(busy4), .done(done4), .p_re(p_re4), .p_tq(p_tq4), .p_tk(p_tk4),
    .p_rdata(p_rdata4), .p_rvalid(p_rvalid4), .m_if(if4), .dbg_state_o(dbg_state4)
  );

  // ---------------- DUT T=5 ----------------
  logic           start5, sm_done5, busy5, done5, p_re5, p_rvalid5;
  logic [RW5-1:0] p_tq5, p_tk5;
  logic [DW-1:0]  p_rdata5;
  pstr_state_t    dbg_state5;
  attention_p_stream_reader_if #(.DATA_W(DW), .ROW_W(RW5)) if5 ();

  attention_p_stream_reader #(.T(T5), .DATA_W(DW), .FIFO_DEPTH(FD)) u_dut5 (
    .clk(clk), .rst_n(rst_n), .start(start5), .sm_done(sm_done5),
    .busy(busy5), .done(done5), .p_re(p_re5), .p_tq(p_tq5), .p_tk(p_tk5),
    .p_rdata(p_rdata5), .p_rvalid(p_rvalid5), .m_if(if5), .dbg_state_o(dbg_state5)
  );

  // ---------------- P source models, fixed 2-cycle latency ----------------
  logic          v4_1 = 1'b0, v4_2 = 1'b0, stray4 = 1'b0;
  logic [31:0]   d4_1 = '0, d4_2 = '0;
  logic          v5_1 = 1'b0, v5_2 = 1'b0;
  logic [31:0]   d5_1 = '0, d5_2 = '0;

  always @(posedge clk) begin
    v4_1 <= p_re4;
    d4_1 <= BASE + 32'(p_tq4) * 32'(T4) + 32'(p_tk4);
    v4_2 <= v4_1;
    d4_2 <= d4_1;
    v5_1 <= p_re5;
    d5_1 <= BASE + 32'(p_tq5) * 32'(T5) + 32'(p_tk5);
    v5_2 <= v5_1;
    d5_2 <= d5_1;
  end
  assign p_rvalid4 = v4_2 | stray4;
  assign p_rdata4  = stray4 ? 32'hDEAD_BEEF : d4_2;
  assign p_rvalid5 = v5_2;
  assign p_rdata5  = d5_2;

  // ---------------- m_ready driver for T=4 ----------------
  int ready_mode = 0;  // 0: always ready, 1: one cycle on / three off, 2: held low
  initial begin
    if4.m_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       if4.m_ready = 1'b1;
        1:       if4.m_ready = (cyc % 4 == 0);
        default: if4.m_ready = 1'b0;
      endcase
    end
  end

  // ---------------- scoreboard ----------------
  // Entry: {data[31:0], row[7:0], col[7:0], last_col, last}
  logic [49:0] exp4_q[$];
  logic [49:0] exp5_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_exp(input int t);
    for (int r = 0; r < t; r++) begin
      for (int c = 0; c < t; c++) begin
        logic [49:0] e;
        e = {BASE + 32'(r * t + c), 8'(r), 8'(c), (c == t - 1), (r == t - 1 && c == t - 1)};
        if (t == T4) exp4_q.push_back(e);
        else         exp5_q.push_back(e);
      end
    end
  endtask

  int          beats4 = 0, dones4 = 0, reqs4 = 0, max_infl4 = 0, done_cyc4 = 0;
  int          beats5 = 0, dones5 = 0;
  logic        hold4 = 1'b0;
  logic [49:0] held4 = '0;

  always @(negedge clk) begin
    logic [49:0] got;
    got = {if4.m_data, 8'(if4.m_row), 8'(if4.m_col), if4.m_last_col, if4.m_last};
    if (!rst_n) begin
      hold4 = 1'b0;
    end else begin
      if (hold4) begin
        check("stall_valid_held", 64'(if4.m_valid), 64'(1));
        check("stall_payload_stable", 64'(got), 64'(held4));
      end
      if (p_re4) reqs4++;
      if (done4) begin
        dones4++;
        done_cyc4 = cyc;
      end
      if (if4.m_valid && if4.m_ready) begin
        beats4++;
        if (exp4_q.size() == 0) check("beat4_unexpected", 64'(got), 64'(0));
        else                    check("beat4", 64'(got), 64'(exp4_q.pop_front()));
      end
      if (reqs4 - beats4 > max_infl4) max_infl4 = reqs4 - beats4;
      hold4 = if4.m_valid && !if4.m_ready;
      held4 = got;
    end
  end

  always @(negedge clk) begin
    logic [49:0] got;
    got = {if5.m_data, 8'(if5.m_row), 8'(if5.m_col), if5.m_last_col, if5.m_last};
    if (rst_n) begin
      if (done5) dones5++;
      if (if5.m_valid && if5.m_ready) begin
        beats5++;
        if (exp5_q.size() == 0) check("beat5_unexpected", 64'(got), 64'(0));
        else                    check("beat5", 64'(got), 64'(exp5_q.pop_front()));
      end
    end
  end

  // ---------------- driver tasks ----------------
  typedef struct {
    int ready_mode;
    int sm_delay;
    int max_lat;    // 0: latency not bounded for this pattern
    int exp_beats;
    int exp_dones;
    int max_infl;
  } vec_t;

  task automatic clear_counts4();
    beats4 = 0; dones4 = 0; reqs4 = 0; max_infl4 = 0;
    exp4_q.delete();
  endtask

  task automatic pulse_start4();
    @(posedge clk); #1 start4 = 1'b1;
    @(posedge clk); #1 start4 = 1'b0;
  endtask

  task automatic wait_done4(input int budget);
    int n = 0;
    while (dones4 == 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    #1;
    if (dones4 == 0) check("done4_timeout", 64'(0), 64'(1));
  endtask

  task automatic run_pass4(input vec_t v);
    int sm_cyc;
    clear_counts4();
    push_exp(T4);
    ready_mode = v.ready_mode;
    pulse_start4();
    check("busy_after_start", 64'(busy4), 64'(1));
    repeat (v.sm_delay) begin @(posedge clk); #1; end
    sm_done4 = 1'b1;
    sm_cyc   = cyc;
    wait_done4(600);
    if (v.max_lat > 0) check("pass_latency_ok", 64'(done_cyc4 - sm_cyc <= v.max_lat), 64'(1));
    repeat (3) begin @(posedge clk); #1; end
    sm_done4 = 1'b0;
    check("pass_beats", 64'(beats4), 64'(v.exp_beats));
    check("pass_reqs", 64'(reqs4), 64'(v.exp_beats));
    check("pass_done_pulses", 64'(dones4), 64'(v.exp_dones));
    check("pass_busy_low", 64'(busy4), 64'(0));
    check("pass_queue_empty", 64'(exp4_q.size()), 64'(0));
    check("pass_credit_bound", 64'(max_infl4 <= v.max_infl), 64'(1));
  endtask

  // ---------------- test sequence ----------------
  vec_t vecs[4];

  initial begin
    int n;
    int beats_at_reset;
    start4 = 1'b0; sm_done4 = 1'b0;
    start5 = 1'b0; sm_done5 = 1'b0;
    if5.m_ready = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs4",
          64'({busy4, done4, p_re4, if4.m_valid, p_tq4, p_tk4, if4.m_data,
               if4.m_row, if4.m_col, if4.m_last_col, if4.m_last}), 64'(0));
    check("reset_state4", 64'(dbg_state4), 64'(IDLE));
    check("reset_outputs5", 64'({busy5, done5, p_re5, if5.m_valid}), 64'(0));
    rst_n = 1'b1;

    vecs[0] = '{ready_mode: 0, sm_delay: 10, max_lat: 22, exp_beats: 16, exp_dones: 1, max_infl: FD};
    vecs[1] = '{ready_mode: 1, sm_delay: 10, max_lat: 0,  exp_beats: 16, exp_dones: 1, max_infl: FD};
    vecs[2] = '{ready_mode: 0, sm_delay: 0,  max_lat: 22, exp_beats: 16, exp_dones: 1, max_infl: FD};
    vecs[3] = '{ready_mode: 1, sm_delay: 3,  max_lat: 0,  exp_beats: 16, exp_dones: 1, max_infl: FD};
    for (int i = 0; i < 4; i++) run_pass4(vecs[i]);

    // Downstream stalled: issue stops at exactly FIFO_DEPTH requests.
    clear_counts4();
    push_exp(T4);
    ready_mode = 2;
    pulse_start4();
    sm_done4 = 1'b1;
    repeat (50) @(posedge clk);
    #1;
    check("stall_reqs", 64'(reqs4), 64'(FD));
    check("stall_p_re_low", 64'(p_re4), 64'(0));
    check("stall_no_beats", 64'(beats4), 64'(0));
    ready_mode = 0;
    wait_done4(300);
    sm_done4 = 1'b0;
    check("stall_beats", 64'(beats4), 64'(16));
    check("stall_queue_empty", 64'(exp4_q.size()), 64'(0));
    check("stall_done_pulses", 64'(dones4), 64'(1));

    // Reset in the middle of a pass, with responses still arriving afterwards.
    clear_counts4();
    push_exp(T4);
    ready_mode = 0;
    pulse_start4();
    sm_done4 = 1'b1;
    n = 0;
    while (beats4 < 6 && n < 200) begin @(posedge clk); n++; end
    check("mid_reset_reached_6", 64'(beats4 >= 6), 64'(1));
    #1 rst_n = 1'b0;
    @(posedge clk); #1;
    check("mid_reset_outputs",
          64'({busy4, done4, p_re4, if4.m_valid, p_tq4, p_tk4, if4.m_data,
               if4.m_row, if4.m_col, if4.m_last_col, if4.m_last}), 64'(0));
    exp4_q.delete();
    sm_done4 = 1'b0;
    rst_n = 1'b1;
    beats_at_reset = beats4;
    @(posedge clk); #1 stray4 = 1'b1;
    @(posedge clk); #1 stray4 = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("stray_no_valid", 64'(if4.m_valid), 64'(0));
    check("stray_not_busy", 64'(busy4), 64'(0));
    check("stray_no_beats", 64'(beats4), 64'(beats_at_reset));
    run_pass4(vecs[2]);

    // sm_done already high at start, plus a start pulse while busy.
    clear_counts4();
    push_exp(T4);
    ready_mode = 0;
    sm_done4 = 1'b1;
    pulse_start4();
    check("pre_done_wait_src", 64'(dbg_state4), 64'(WAIT_SRC));
    @(posedge clk); #1;
    check("pre_done_issue_p_re", 64'(p_re4), 64'(1));
    repeat (3) begin @(posedge clk); #1; end
    start4 = 1'b1;
    @(posedge clk); #1 start4 = 1'b0;
    wait_done4(300);
    repeat (20) begin @(posedge clk); #1; end
    check("busy_start_done_pulses", 64'(dones4), 64'(1));
    check("busy_start_idle_after", 64'(busy4), 64'(0));
    check("busy_start_beats", 64'(beats4), 64'(16));
    check("busy_start_queue_empty", 64'(exp4_q.size()), 64'(0));
    sm_done4 = 1'b0;

    // T=5: non-power-of-two wrap.
    push_exp(T5);
    @(posedge clk); #1 start5 = 1'b1;
    @(posedge clk); #1 start5 = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    sm_done5 = 1'b1;
    n = 0;
    while (dones5 == 0 && n < 400) begin @(posedge clk); n++; end
    #1;
    if (dones5 == 0) check("done5_timeout", 64'(0), 64'(1));
    repeat (3) begin @(posedge clk); #1; end
    sm_done5 = 1'b0;
    check("t5_beats", 64'(beats5), 64'(25));
    check("t5_queue_empty", 64'(exp5_q.size()), 64'(0));
    check("t5_done_pulses", 64'(dones5), 64'(1));
    check("t5_busy_low", 64'(busy5), 64'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
